// File: rtl/ie_branch_unit_pkg.sv
// ie_branch_unit_pkg: shared status bit indices, op codes, FSM states and helpers
package ie_branch_unit_pkg;

    localparam int C_BIT = 0;
    localparam int Z_BIT = 1;
    localparam int V_BIT = 6;
    localparam int N_BIT = 7;
    localparam int OP_W  = 8;

    typedef enum logic [OP_W-1:0] {
        OP_BCC = 8'h04,
        OP_BCS = 8'h05,
        OP_BEQ = 8'h06,
        OP_BMI = 8'h07,
        OP_BNE = 8'h08,
        OP_BPL = 8'h09,
        OP_BVC = 8'h0A,
        OP_BVS = 8'h0B,
        OP_JMP = 8'h1C
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EVAL,
        S_PENALTY,
        S_PAGEFIX,
        S_RD_LO,
        S_RD_HI,
        S_FIN
    } bu_state_e;

    function automatic logic is_branch(input logic [OP_W-1:0] op);
        return (op >= OP_BCC) && (op <= OP_BVS);
    endfunction

endpackage

// File: rtl/ie_branch_unit_if.sv
// ie_branch_unit_if: request/result and memory-read signals of the branch unit
interface ie_branch_unit_if
    import ie_branch_unit_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 8
);
    logic            start;
    logic [OP_W-1:0] op;
    logic            jmp_ind;
    logic [AW-1:0]   operand;
    logic [AW-1:0]   pc_in;
    logic [DW-1:0]   status;
    logic [AW-1:0]   mem_addr;
    logic            mem_rd;
    logic [DW-1:0]   mem_rdata;
    logic            mem_ack;
    logic            busy;
    logic            done;
    logic [AW-1:0]   pc_out;
    logic            pc_load;
    logic            taken;
    logic            err;

    modport master (
        output start, op, jmp_ind, operand, pc_in, status, mem_rdata, mem_ack,
        input  mem_addr, mem_rd, busy, done, pc_out, pc_load, taken, err
    );

    modport slave (
        input  start, op, jmp_ind, operand, pc_in, status, mem_rdata, mem_ack,
        output mem_addr, mem_rd, busy, done, pc_out, pc_load, taken, err
    );
endinterface

// File: rtl/ie_branch_unit_cond.sv
// ie_branch_unit_cond: evaluates a conditional branch code against the P flags
module ie_branch_unit_cond
    import ie_branch_unit_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [OP_W-1:0] op_i,
    input  logic [DW-1:0]   status_i,
    output logic            cond_o,
    output logic            valid_o
);
    logic unused_status;

    assign unused_status = ^status_i[5:2];
    assign valid_o       = is_branch(op_i);

    // Flag test per branch code; non-branch codes never report a true condition
    always_comb begin
        cond_o = 1'b0;
        case (op_i)
            OP_BCC:  cond_o = !status_i[C_BIT];
            OP_BCS:  cond_o = status_i[C_BIT];
            OP_BEQ:  cond_o = status_i[Z_BIT];
            OP_BNE:  cond_o = !status_i[Z_BIT];
            OP_BMI:  cond_o = status_i[N_BIT];
            OP_BPL:  cond_o = !status_i[N_BIT];
            OP_BVC:  cond_o = !status_i[V_BIT];
            OP_BVS:  cond_o = status_i[V_BIT];
            default: cond_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/ie_branch_unit.sv
// ie_branch_unit: 6502 branch/JMP execute unit with cycle-accurate penalties
module ie_branch_unit
    import ie_branch_unit_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 8
) (
    input logic             clk,
    input logic             rst,
    ie_branch_unit_if.slave bus
);
    bu_state_e       state_q;
    logic [OP_W-1:0] op_q;
    logic            jmp_ind_q;
    logic [AW-1:0]   operand_q;
    logic [AW-1:0]   pc_in_q;
    logic [DW-1:0]   status_q;
    logic [AW-1:0]   tgt_q;
    logic [DW-1:0]   lo_q;
    logic [AW-1:0]   mem_addr_q;
    logic            mem_rd_q;
    logic            busy_q;
    logic            done_q;
    logic [AW-1:0]   pc_out_q;
    logic            pc_load_q;
    logic            taken_q;
    logic            err_q;
    logic            cond;
    logic            cond_valid;
    logic            is_jmp;
    logic [AW-1:0]   tgt_d;
    logic [AW-1:0]   hi_addr_d;

    ie_branch_unit_cond #(.DW(DW)) u_cond (
        .op_i     (op_q),
        .status_i (status_q),
        .cond_o   (cond),
        .valid_o  (cond_valid)
    );

    assign is_jmp    = (op_q == OP_JMP);
    assign tgt_d     = pc_in_q + {{(AW-8){operand_q[7]}}, operand_q[7:0]};
    // The 6502 indirect-JMP bug: the pointer's low byte wraps without carrying
    assign hi_addr_d = {operand_q[AW-1:8], operand_q[7:0] + 8'd1};

    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_rd   = mem_rd_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pc_out   = pc_out_q;
    assign bus.pc_load  = pc_load_q;
    assign bus.taken    = taken_q;
    assign bus.err      = err_q;

    // Control FSM with registered outputs; FIN doubles as an accept state for back-to-back ops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            jmp_ind_q  <= 1'b0;
            operand_q  <= '0;
            pc_in_q    <= '0;
            status_q   <= '0;
            tgt_q      <= '0;
            lo_q       <= '0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pc_out_q   <= '0;
            pc_load_q  <= 1'b0;
            taken_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_FIN: begin
                    pc_load_q <= 1'b0;
                    taken_q   <= 1'b0;
                    err_q     <= 1'b0;
                    state_q   <= S_IDLE;
                    if (bus.start) begin
                        op_q      <= bus.op;
                        jmp_ind_q <= bus.jmp_ind;
                        operand_q <= bus.operand;
                        pc_in_q   <= bus.pc_in;
                        status_q  <= bus.status;
                        busy_q    <= 1'b1;
                        state_q   <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (cond_valid && cond) begin
                        tgt_q   <= tgt_d;
                        state_q <= S_PENALTY;
                    end else if (is_jmp && jmp_ind_q) begin
                        mem_addr_q <= operand_q;
                        mem_rd_q   <= 1'b1;
                        state_q    <= S_RD_LO;
                    end else begin
                        pc_out_q  <= is_jmp ? operand_q : pc_in_q;
                        pc_load_q <= is_jmp;
                        taken_q   <= is_jmp;
                        err_q     <= !is_jmp && !cond_valid;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= S_FIN;
                    end
                end
                S_PENALTY, S_PAGEFIX: begin
                    if (state_q == S_PENALTY && tgt_q[AW-1:8] != pc_in_q[AW-1:8]) begin
                        state_q <= S_PAGEFIX;
                    end else begin
                        pc_out_q  <= tgt_q;
                        pc_load_q <= 1'b1;
                        taken_q   <= 1'b1;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= S_FIN;
                    end
                end
                S_RD_LO: begin
                    if (mem_rd_q && bus.mem_ack) begin
                        lo_q       <= bus.mem_rdata;
                        mem_rd_q   <= 1'b0;
                        mem_addr_q <= hi_addr_d;
                        state_q    <= S_RD_HI;
                    end
                end
                S_RD_HI: begin
                    if (!mem_rd_q) begin
                        mem_rd_q <= 1'b1;
                    end else if (bus.mem_ack) begin
                        mem_rd_q  <= 1'b0;
                        pc_out_q  <= {bus.mem_rdata, lo_q};
                        pc_load_q <= 1'b1;
                        taken_q   <= 1'b1;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= S_FIN;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ie_branch_unit.sv
// tb_ie_branch_unit: directed plus randomized checks against a flag/arithmetic reference model
module tb_ie_branch_unit;

    typedef struct {
        int lat;
        bit ld;
        bit tk;
        bit er;
        int pc;
        int a0;
        int a1;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int passes = 0;
    int checks = 0;
    int fails = 0;
    int ack_delay = 0;
    int wait_cnt = 0;
    logic [15:0] rd_log[$];
    logic [7:0] mem[int];

    ie_branch_unit_if #(.AW(16), .DW(8)) bus ();

    ie_branch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input int a);
        return mem.exists(a) ? mem[a] : (a[7:0] ^ a[15:8] ^ 8'h5A);
    endfunction

    // Memory responder: acks a pending read after ack_delay cycles and logs each address
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (bus.mem_rd && !rst) begin
                if (wait_cnt == 0) begin
                    bus.mem_rdata = mem_byte(int'(bus.mem_addr));
                    bus.mem_ack   = 1'b1;
                    rd_log.push_back(bus.mem_addr);
                    wait_cnt = ack_delay;
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] op, input bit ind, input int opnd,
                                   input int pc, input logic [7:0] p);
        exp_t e;
        bit c;
        int off;
        e = '{lat: 2, ld: 0, tk: 0, er: 0, pc: 0, a0: 0, a1: 0};
        c = 0;
        case (op)
            8'h04: c = !p[0];
            8'h05: c = p[0];
            8'h06: c = p[1];
            8'h07: c = p[7];
            8'h08: c = !p[1];
            8'h09: c = !p[7];
            8'h0A: c = !p[6];
            8'h0B: c = p[6];
            8'h1C: begin
                e.ld = 1;
                e.tk = 1;
                if (!ind) e.pc = opnd;
                else begin
                    e.lat = -1;
                    e.a0  = opnd;
                    e.a1  = (opnd / 256) * 256 + ((opnd + 1) % 256);
                    e.pc  = mem_byte(e.a1) * 256 + mem_byte(e.a0);
                end
                return e;
            end
            default: begin
                e.er = 1;
                return e;
            end
        endcase
        if (c) begin
            off  = opnd % 256;
            off  = (off >= 128) ? off - 256 : off;
            e.pc = (pc + off + 65536) % 65536;
            e.ld = 1;
            e.tk = 1;
            e.lat = (e.pc / 256 == pc / 256) ? 3 : 4;
        end
        return e;
    endfunction

    // Issue one op at the current negedge and check its result at the done cycle
    task automatic run(input logic [7:0] op, input bit ind, input logic [15:0] opnd,
                       input logic [15:0] pc, input logic [7:0] p, input bit poke);
        exp_t e;
        int k;
        e = model(op, ind, int'(opnd), int'(pc), p);
        bus.op      = op;
        bus.jmp_ind = ind;
        bus.operand = opnd;
        bus.pc_in   = pc;
        bus.status  = p;
        bus.start   = 1'b1;
        rd_log.delete();
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                bus.start = poke;
                if (poke) begin
                    bus.op      = 8'h1C;
                    bus.jmp_ind = 1'b0;
                    bus.operand = 16'hFFFF;
                end
                chk("busy_eval", bus.busy, 1);
                chk("done_eval", bus.done, 0);
            end
            if (k == 2) bus.start = 1'b0;
        end while (!bus.done && k < 60);
        chk("done_seen", bus.done, 1);
        if (e.lat > 0) chk("latency", k, e.lat);
        chk("busy_fin", bus.busy, 0);
        chk("pc_load", bus.pc_load, e.ld);
        chk("taken", bus.taken, e.tk);
        chk("err", bus.err, e.er);
        if (e.ld) chk("pc_out", bus.pc_out, e.pc);
        if (op == 8'h1C && ind) begin
            chk("rd_count", rd_log.size(), 2);
            if (rd_log.size() == 2) begin
                chk("rd_addr0", rd_log[0], e.a0);
                chk("rd_addr1", rd_log[1], e.a1);
            end
        end
    endtask

    initial begin
        logic [7:0] op;
        int r;
        int v;
        bit seen;
        bus.start   = 1'b0;
        bus.op      = 8'h00;
        bus.jmp_ind = 1'b0;
        bus.operand = 16'h0000;
        bus.pc_in   = 16'h0000;
        bus.status  = 8'h00;
        mem[16'h10FF] = 8'h34;
        mem[16'h1000] = 8'h12;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_mem_rd", bus.mem_rd, 0);
        chk("rst_pc_out", bus.pc_out, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_flags", {bus.pc_load, bus.taken, bus.err}, 0);
        rst = 1'b0;
        @(negedge clk);

        run(8'h06, 0, 16'h0010, 16'h1234, 8'h02, 0);
        @(negedge clk);
        run(8'h08, 0, 16'h0010, 16'h1234, 8'h02, 0);
        @(negedge clk);
        run(8'h07, 0, 16'h00F0, 16'h1205, 8'h80, 0);
        @(negedge clk);
        run(8'h05, 0, 16'h0020, 16'hFFF0, 8'h01, 0);
        run(8'h0B, 0, 16'h0080, 16'h4000, 8'h40, 0);
        run(8'h1C, 0, 16'hBEEF, 16'h0300, 8'h00, 0);
        @(negedge clk);
        ack_delay = 3;
        wait_cnt  = 3;
        run(8'h1C, 1, 16'h10FF, 16'h0300, 8'h00, 0);
        @(negedge clk);
        run(8'h00, 0, 16'h1234, 16'h0300, 8'hFF, 0);
        @(negedge clk);
        run(8'h07, 0, 16'h00F0, 16'h1205, 8'h80, 1);
        @(negedge clk);

        ack_delay = 2;
        wait_cnt  = 2;
        bus.op      = 8'h1C;
        bus.jmp_ind = 1'b1;
        bus.operand = 16'h2000;
        bus.start   = 1'b1;
        rd_log.delete();
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 30 && rd_log.size() == 0; i++) @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("rd_hi_req", bus.mem_rd, 1);
        rst = 1'b1;
        #1;
        chk("rst_async_mem_rd", bus.mem_rd, 0);
        chk("rst_async_busy", bus.busy, 0);
        chk("rst_async_done", bus.done, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_cnt = ack_delay;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen |= bus.done | bus.mem_rd;
        end
        chk("no_done_after_rst", seen, 0);
        run(8'h1C, 0, 16'h8000, 16'h0300, 8'h00, 0);
        @(negedge clk);

        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 11);
            if (r < 8) op = 8'(8'h04 + r);
            else if (r < 10) op = 8'h1C;
            else begin
                v  = $urandom_range(0, 255);
                op = ((v >= 4 && v <= 11) || v == 28) ? 8'h00 : 8'(v);
            end
            ack_delay = $urandom_range(0, 3);
            wait_cnt  = ack_delay;
            run(op, 1'($urandom), 16'($urandom), 16'($urandom), 8'($urandom),
                $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
